// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; clear has priority over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = ptr_width(Depth),
  localparam int unsigned CntW = cnt_width(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  fetch_entry_t    wdata_i,
  output fetch_entry_t    rdata_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o && !clear_i;
  assign do_push = push_i && !clear_i && (!full || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (clear_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // The issue rule reserves space for every outstanding response.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_i && !pop_i && !clear_i) begin
      assert (!full);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: imem request issue, prefetch buffering and the IF/ID register.
// Define FETCH_PERF_EN to add the bubble/drop performance counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        InstrValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubble_cnt,
  output logic [31:0] fetch_drop_cnt
`endif
);

  localparam int unsigned CntW = cnt_width(FIFO_DEPTH);
  localparam int unsigned OutW = cnt_width(MAX_OUTST);

  logic [31:0]     pcf_q, pcf_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [OutW-1:0] outst_q, outst_d;
  logic [OutW-1:0] drop_q, drop_d;
  logic [31:0]     instr_q, instr_d, pcd_q, pcd_d, pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic            accept, dropping, push, pop, starved;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    head;

  assign imem_req_valid = rst && !StallF && !PCSrcE
                          && ((32'(fifo_count) + 32'(outst_q)) < FIFO_DEPTH)
                          && (32'(outst_q) < MAX_OUTST);
  assign imem_req_addr  = pcf_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign dropping       = imem_rsp_valid && (PCSrcE || (drop_q != '0));
  assign push           = imem_rsp_valid && !dropping;
  assign pop            = !PCSrcE && !FlushD && !StallD && !fifo_empty;
  assign starved        = !PCSrcE && !FlushD && !StallD && fifo_empty;

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (PCSrcE),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ('{instr: imem_rsp_data, pc: rsp_pc_q}),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Responses return in order and requests are sequential between redirects,
  // so the PC of the next kept response is a running address.
  always_comb begin
    pcf_d    = pcf_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    outst_d  = outst_q + OutW'(accept) - OutW'(imem_rsp_valid);
    if (PCSrcE) begin
      pcf_d    = PCTargetE;
      rsp_pc_d = PCTargetE;
      drop_d   = outst_q - OutW'(imem_rsp_valid);
    end else begin
      if (accept) pcf_d = pcf_q + PC_STEP;
      if (push) rsp_pc_d = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - OutW'(1);
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (PCSrcE || FlushD || starved) begin
      instr_d = INSTR_BUBBLE;
      pcd_d   = '0;
      pcp4_d  = PC_STEP;
      valid_d = 1'b0;
    end else if (pop) begin
      instr_d = head.instr;
      pcd_d   = head.pc;
      pcp4_d  = head.pc + PC_STEP;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcf_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      instr_q  <= INSTR_BUBBLE;
      pcd_q    <= '0;
      pcp4_q   <= PC_STEP;
      valid_q  <= 1'b0;
    end else begin
      pcf_q    <= pcf_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      pcp4_q   <= pcp4_d;
      valid_q  <= valid_d;
    end
  end

  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pcp4_q;
  assign InstrValidD = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (starved)  bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (dropping) drop_cnt_q   <= drop_cnt_q + 32'd1;
    end
  end

  assign fetch_bubble_cnt = bubble_cnt_q;
  assign fetch_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an in-order, fixed-latency memory model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        InstrValidD;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubble_cnt, fetch_drop_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (2),
    .MAX_OUTST  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .InstrValidD    (InstrValidD)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubble_cnt (fetch_bubble_cnt),
    .fetch_drop_cnt   (fetch_drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_instr  = 0;
  int lat      = 1;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } mreq_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  mreq_t       mq[$];
  exp_t        exp_q[$];
  logic [31:0] exp_pc = RPC;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory contents: 0x100 holds 32'hC0DE_0100, 0x200 holds 32'hC0DE_0200, etc.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!InstrValidD && k < budget) begin
      tick(1);
      k++;
    end
    if (!InstrValidD) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: InstrValidD still 0 after %0d cycles, required 1", name, budget);
    end
  endtask

  task automatic wait_outst(input string name, input logic rsp_now, input int budget);
    int k = 0;
    while (!(mq.size() == 2 && imem_rsp_valid == rsp_now) && k < budget) begin
      tick(1);
      k++;
    end
    if (!(mq.size() == 2 && imem_rsp_valid == rsp_now)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: outstanding %0d rsp %0b, required 2 and %0b", name, mq.size(),
               imem_rsp_valid, rsp_now);
    end
  endtask

  // Memory model and stimulus-side scoreboard push: bookkeeping mid-cycle, drive after the edge.
  initial begin
    mreq_t tmp;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        mq.delete();
        exp_q.delete();
        exp_pc = RPC;
      end else begin
        if (imem_rsp_valid && mq.size() > 0) tmp = mq.pop_front();
        if (PCSrcE) begin
          check32("req_valid_in_redirect", {31'b0, imem_req_valid}, 32'd0);
          exp_q.delete();
          exp_pc = PCTargetE;
        end else if (imem_req_valid && imem_req_ready) begin
          check32("req_addr", imem_req_addr, exp_pc);
          mq.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
          exp_q.push_back('{instr: mem_word(exp_pc), pc: exp_pc});
          exp_pc = exp_pc + 32'd4;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor: compares each newly loaded IF/ID entry against the scoreboard.
  initial begin
    logic        ld;
    logic [31:0] last_instr, last_pc;
    exp_t        e;
    ld         = 1'b0;
    last_instr = '0;
    last_pc    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ld = 1'b0;
      end else begin
        if (ld && InstrValidD) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL if_id_unexpected: got pc %h, required no instruction", PCD);
          end else begin
            e = exp_q.pop_front();
            check32("if_id_instr", InstrD, e.instr);
            check32("if_id_pc", PCD, e.pc);
            check32("if_id_pcplus4", PCPlus4D, e.pc + 32'd4);
            n_instr++;
          end
        end else if (!ld && InstrValidD) begin
          check32("hold_instr", InstrD, last_instr);
          check32("hold_pc", PCD, last_pc);
        end
        last_instr = InstrD;
        last_pc    = PCD;
        ld         = !StallD || FlushD || PCSrcE;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    StallF         = 1'b0;
    StallD         = 1'b0;
    FlushD         = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = '0;
    imem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check32("rst_instr", InstrD, 32'h0);
    check32("rst_pcd", PCD, 32'h0);
    check32("rst_pcplus4", PCPlus4D, 32'h4);
    check32("rst_valid", {31'b0, InstrValidD}, 32'd0);
    check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick(2);
    rst = 1'b1;

    // Memory not ready: address must stay at the reset PC, no instructions.
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check32("noready_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check32("noready_addr", imem_req_addr, RPC);
      check32("noready_bubble", {31'b0, InstrValidD}, 32'd0);
    end
    StallF = 1'b1;
    #1 check32("stallf_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    StallF = 1'b0;

    // Streaming with 1-cycle memory.
    imem_req_ready = 1'b1;
    wait_valid("first_fill", 20);
    check32("first_instr", InstrD, 32'hC0DE_0100);
    check32("first_pcd", PCD, 32'h0000_0100);
    check32("first_pcplus4", PCPlus4D, 32'h0000_0104);
    tick(10);

    // Decode stall until the FIFO fills: no requests while count + outstanding = 2.
    StallD = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check32("staild_full_no_req", {31'b0, imem_req_valid}, 32'd0);
      tick(1);
    end
    StallD = 1'b0;
    tick(6);

    // Flush wins over stall and leaves the FIFO intact.
    FlushD = 1'b1;
    StallD = 1'b1;
    tick(1);
    check32("flush_bubble", {31'b0, InstrValidD}, 32'd0);
    FlushD = 1'b0;
    StallD = 1'b0;
    tick(6);

    // Redirect with two requests outstanding and no response this cycle.
    lat = 3;
    wait_outst("redirect_setup", 1'b0, 40);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0200;
    #1 check32("redirect_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick(1);
    PCSrcE = 1'b0;
    check32("redirect_bubble", {31'b0, InstrValidD}, 32'd0);
    check32("redirect_next_addr", imem_req_addr, 32'h0000_0200);
    wait_valid("redirect_fill", 40);
    check32("redirect_pcd", PCD, 32'h0000_0200);
    tick(4);

    // Redirect together with StallD and a same-cycle response.
    wait_outst("redirect2_setup", 1'b1, 40);
    PCSrcE    = 1'b1;
    StallD    = 1'b1;
    PCTargetE = 32'h0000_0300;
    tick(1);
    check32("redirect_stall_bubble", {31'b0, InstrValidD}, 32'd0);
    PCSrcE = 1'b0;
    StallD = 1'b0;
    wait_valid("redirect2_fill", 40);
    check32("redirect2_pcd", PCD, 32'h0000_0300);
    check32("redirect2_instr", InstrD, 32'hC0DE_0300);
    tick(4);

    // Asynchronous reset mid-burst.
    lat = 2;
    tick(5);
    rst = 1'b0;
    #1;
    check32("midrst_instr", InstrD, 32'h0);
    check32("midrst_pcd", PCD, 32'h0);
    check32("midrst_pcplus4", PCPlus4D, 32'h4);
    check32("midrst_valid", {31'b0, InstrValidD}, 32'd0);
    check32("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
`ifdef FETCH_PERF_EN
    check32("midrst_bubble_cnt", fetch_bubble_cnt, 32'd0);
    check32("midrst_drop_cnt", fetch_drop_cnt, 32'd0);
`endif
    tick(2);
    rst = 1'b1;
    #1 check32("postrst_addr", imem_req_addr, RPC);
    wait_valid("postrst_fill", 20);
    check32("postrst_pcd", PCD, RPC);
    tick(8);

    n_checks++;
    if (n_instr < 10) begin
      n_fail++;
      $display("FAIL instr_count: got %0d instructions, required at least 10", n_instr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
